// File: rtl/agc_gain_apply.sv
// agc_gain_apply: AGC gain smoothing FSM plus 3-stage I/Q gain multiply with symmetric saturation; AGC_GAIN_APPLY_SAT_COUNT_EN adds the saturation counter
module agc_gain_apply #(
  parameter logic [31:0] GAIN_MAX     = 32'h00FF_FFFF,
  parameter int          SETTLE_BEATS = 64,
  parameter int          STEP_SHIFT   = 3
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] gain_in,
  input  logic        gain_valid,
  input  logic        freeze,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] gain_applied,
  output logic [1:0]  state_out,
  output logic [15:0] sat_count,
  input  logic        sat_clr
);
  localparam logic [31:0] UNITY = 32'h0001_0000;
  localparam int CW = $clog2(SETTLE_BEATS + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, TRACK, HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic en, acc;
  logic [31:0] g_t, g_nxt;
  logic signed [32:0] diff, step;
  logic signed [33:0] sum;
  logic v1, v2;
  logic [15:0] i1, q1;
  logic [31:0] g1;
  logic [47:0] p_i, p_q;
  logic [16:0] si, sq;
  assign en = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign acc = s_axis_tvalid && en;
  assign state_out = state;
  assign g_t = gain_in > GAIN_MAX ? GAIN_MAX : gain_in;
  assign diff = $signed({1'b0, g_t}) - $signed({1'b0, gain_applied});
  assign step = diff >>> STEP_SHIFT;
  assign sum = $signed({step[32], step}) + $signed({2'b00, gain_applied});
  assign g_nxt = sum[33] ? 32'd0 : (sum[32:0] > {1'b0, GAIN_MAX}) ? GAIN_MAX : sum[31:0];
  // round by 2^15, shift by 16, clamp to +/-32767; bit 16 flags saturation
  function automatic logic [16:0] sat(input logic [47:0] p);
    logic signed [47:0] r;
    r = ($signed(p) + 48'sd32768) >>> 16;
    sat = r > 48'sd32767 ? {1'b1, 16'h7FFF} : r < -48'sd32767 ? {1'b1, 16'h8001} : {1'b0, r[15:0]};
  endfunction
  assign si = sat(p_i);
  assign sq = sat(p_q);
  // gain state machine: direct load, settle over accepted beats, smoothed tracking, freeze hold
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state <= IDLE;
      gain_applied <= UNITY;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (gain_valid) begin
          gain_applied <= g_t;
          cnt <= '0;
          state <= SETTLE;
        end
        SETTLE: if (acc) begin
          cnt <= cnt == CW'(SETTLE_BEATS - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(SETTLE_BEATS - 1)) state <= TRACK;
        end
        TRACK: if (freeze) state <= HOLD;
          else if (gain_valid) gain_applied <= g_nxt;
        HOLD: if (!freeze) state <= TRACK;
      endcase
    end
  end
  // capture, multiply, round/saturate stages all advance together on en
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      {v1, v2, m_axis_tvalid} <= '0;
      {i1, q1, g1, p_i, p_q} <= '0;
      m_axis_tdata <= '0;
    end else if (en) begin
      v1 <= acc;
      i1 <= s_axis_tdata[15:0];
      q1 <= s_axis_tdata[31:16];
      g1 <= gain_applied;
      v2 <= v1;
      p_i <= $signed({{32{i1[15]}}, i1}) * $signed({16'b0, g1});
      p_q <= $signed({{32{q1[15]}}, q1}) * $signed({16'b0, g1});
      m_axis_tvalid <= v2;
      m_axis_tdata <= {sq[15:0], si[15:0]};
    end
  end
`ifdef AGC_GAIN_APPLY_SAT_COUNT_EN
  logic sat3;
  // saturation flag travels alongside the output register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) sat3 <= 1'b0;
    else if (en) sat3 <= si[16] | sq[16];
  end
  // count saturated beats at the output handshake, clear has priority, stick at max
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) sat_count <= '0;
    else if (sat_clr) sat_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && sat3 && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
  end
`else
  logic unused;
  assign unused = ^{sat_clr, si[16], sq[16]};
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_agc_gain_apply.sv
// tb_agc_gain_apply: directed self-checking bench for agc_gain_apply
module tb_agc_gain_apply;
`ifdef AGC_GAIN_APPLY_SAT_COUNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clk = 1'b0, arst = 1'b0;
  logic [31:0] s_axis_tdata = '0, gain_in = '0, m_axis_tdata, gain_applied;
  logic s_axis_tvalid = 1'b0, s_axis_tready, gain_valid = 1'b0, freeze = 1'b0;
  logic m_axis_tvalid, m_axis_tready = 1'b1, sat_clr = 1'b0;
  logic [1:0] state_out;
  logic [15:0] sat_count;
  int checks = 0, errors = 0;

  agc_gain_apply dut (
    .clk(clk), .arst(arst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .gain_in(gain_in), .gain_valid(gain_valid), .freeze(freeze),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .gain_applied(gain_applied), .state_out(state_out), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic hard_reset;
    @(negedge clk) arst = 1'b0;
    @(negedge clk) arst = 1'b1;
  endtask

  task automatic pulse_gain(input logic [31:0] g);
    @(negedge clk);
    gain_in = g;
    gain_valid = 1'b1;
    @(posedge clk);
    #1 gain_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    @(negedge clk) s_axis_tvalid = 1'b1;
    repeat (n) @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic run_beat(input logic [15:0] i, input logic [15:0] q, output logic early, output logic [31:0] d, output logic v);
    @(negedge clk);
    s_axis_tdata = {q, i};
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1 early = m_axis_tvalid;
    @(posedge clk);
    #1 d = m_axis_tdata;
    v = m_axis_tvalid;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [15:0] a, b;
    a = 16'($urandom_range(0, 65534)) - 16'd32767;
    b = 16'($urandom_range(0, 65534)) - 16'd32767;
    return {b, a};
  endfunction

  task automatic test_reset;
    #12;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
    checks++; if (gain_applied !== 32'h0001_0000) begin errors++; $display("FAIL rst_gain got %h exp 00010000", gain_applied); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_out); end
    checks++; if (sat_count !== 16'h0) begin errors++; $display("FAIL rst_sat got %h exp 0", sat_count); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b exp 1", s_axis_tready); end
    @(negedge clk) arst = 1'b1;
  endtask

  task automatic test_unity;
    logic e, v;
    logic [31:0] d;
    run_beat(16'd1000, -16'sd1000, e, d, v);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL unity_early got %b exp 0", e); end
    checks++; if (v !== 1'b1 || d !== 32'hFC18_03E8) begin errors++; $display("FAIL unity_data got %b/%h exp 1/fc1803e8", v, d); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL unity_state got %0d exp 0", state_out); end
    run_beat(16'h8000, 16'h7FFF, e, d, v);
    checks++; if (d !== 32'h7FFF_8001) begin errors++; $display("FAIL unity_min got %h exp 7fff8001", d); end
  endtask

  task automatic test_settle;
    logic e, v;
    logic [31:0] d;
    pulse_gain(32'h0002_8000);
    checks++; if (gain_applied !== 32'h0002_8000 || state_out !== 2'd1) begin errors++; $display("FAIL settle_load got %h/%0d exp 00028000/1", gain_applied, state_out); end
    run_beat(16'd1001, -16'sd1001, e, d, v);
    checks++; if (d !== 32'hF63A_09C7) begin errors++; $display("FAIL settle_mult got %h exp f63a09c7", d); end
    pulse_gain(32'h0005_0000);
    checks++; if (gain_applied !== 32'h0002_8000) begin errors++; $display("FAIL settle_ignore got %h exp 00028000", gain_applied); end
    @(negedge clk) freeze = 1'b1;
    @(posedge clk);
    #1 freeze = 1'b0;
    stream(62);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL settle_63 got %0d exp 1", state_out); end
    stream(1);
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL settle_64 got %0d exp 2", state_out); end
  endtask

  task automatic test_track;
    hard_reset();
    pulse_gain(32'h0001_0000);
    stream(64);
    checks++; if (state_out !== 2'd2 || gain_applied !== 32'h0001_0000) begin errors++; $display("FAIL track_entry got %0d/%h exp 2/00010000", state_out, gain_applied); end
    pulse_gain(32'h0009_0000);
    checks++; if (gain_applied !== 32'h0002_0000) begin errors++; $display("FAIL track_up got %h exp 00020000", gain_applied); end
    pulse_gain(32'hFFFF_FFFF);
    checks++; if (gain_applied !== 32'h0021_BFFF) begin errors++; $display("FAIL track_clamp got %h exp 0021bfff", gain_applied); end
    pulse_gain(32'h0);
    checks++; if (gain_applied !== 32'h001D_87FF) begin errors++; $display("FAIL track_down got %h exp 001d87ff", gain_applied); end
  endtask

  task automatic test_freeze;
    @(negedge clk);
    freeze = 1'b1;
    gain_valid = 1'b1;
    gain_in = 32'h0009_0000;
    @(posedge clk);
    #1 gain_valid = 1'b0;
    checks++; if (gain_applied !== 32'h001D_87FF || state_out !== 2'd3) begin errors++; $display("FAIL freeze_enter got %h/%0d exp 001d87ff/3", gain_applied, state_out); end
    pulse_gain(32'h0009_0000);
    checks++; if (gain_applied !== 32'h001D_87FF) begin errors++; $display("FAIL freeze_hold got %h exp 001d87ff", gain_applied); end
    @(negedge clk) freeze = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL freeze_exit got %0d exp 2", state_out); end
  endtask

  task automatic test_saturation;
    logic e, v;
    logic [31:0] d;
    hard_reset();
    pulse_gain(32'h0010_0000);
    run_beat(16'd4000, 16'd0, e, d, v);
    checks++; if (d !== 32'h0000_7FFF) begin errors++; $display("FAIL sat_pos got %h exp 00007fff", d); end
    run_beat(-16'sd4000, 16'd100, e, d, v);
    checks++; if (d !== 32'h0640_8001) begin errors++; $display("FAIL sat_neg got %h exp 06408001", d); end
    run_beat(16'd100, -16'sd100, e, d, v);
    checks++; if (d !== 32'hF9C0_0640) begin errors++; $display("FAIL sat_none got %h exp f9c00640", d); end
    @(posedge clk);
    #1;
    checks++; if (sat_count !== (SAT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL sat_count got %0d exp %0d", sat_count, SAT_EN ? 2 : 0); end
    run_beat(16'd4000, 16'd0, e, d, v);
    @(negedge clk) sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", sat_count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    logic [31:0] held, cur, want;
    logic stalled;
    int sent, got, cyc;
    hard_reset();
    stalled = 1'b0;
    held = '0;
    sent = 0;
    got = 0;
    cyc = 0;
    cur = rnd_word();
    while (got < 300 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      m_axis_tready = $urandom_range(0, 9) >= 3;
      s_axis_tvalid = sent < 300;
      s_axis_tdata = cur;
      #1;
      if (stalled) begin
        checks++; if (m_axis_tdata !== held) begin errors++; $display("FAIL bp_stable got %h exp %h", m_axis_tdata, held); end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got %h exp none", m_axis_tdata); end
        else begin
          want = exp_q.pop_front();
          if (m_axis_tdata !== want) begin errors++; $display("FAIL bp_data got %h exp %h", m_axis_tdata, want); end
        end
        got++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(cur);
        sent++;
        cur = rnd_word();
      end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    checks++; if (got != 300) begin errors++; $display("FAIL bp_count got %0d exp 300", got); end
  endtask

  task automatic test_reset_midstream;
    logic e, v;
    logic [31:0] d;
    hard_reset();
    pulse_gain(32'h0002_8000);
    @(negedge clk);
    s_axis_tdata = 32'h0100_0100;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 arst = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0) begin errors++; $display("FAIL mid_out got %b/%h exp 0/0", m_axis_tvalid, m_axis_tdata); end
    checks++; if (gain_applied !== 32'h0001_0000 || state_out !== 2'd0) begin errors++; $display("FAIL mid_gain got %h/%0d exp 00010000/0", gain_applied, state_out); end
    checks++; if (s_axis_tready !== 1'b1 || sat_count !== 16'h0) begin errors++; $display("FAIL mid_misc got %b/%h exp 1/0", s_axis_tready, sat_count); end
    s_axis_tvalid = 1'b0;
    @(negedge clk) arst = 1'b1;
    run_beat(16'd1000, -16'sd1000, e, d, v);
    checks++; if (e !== 1'b0 || v !== 1'b1 || d !== 32'hFC18_03E8) begin errors++; $display("FAIL mid_after got %b/%b/%h exp 0/1/fc1803e8", e, v, d); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_settle();
    test_track();
    test_freeze();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
